// File: rtl/ioc_bus_master.sv
// ioc_bus_master: decodes host command bytes into IOC register strobes for
// four targets, returns read-back bytes, and keeps a saturating error count.
module ioc_bus_master #(
    parameter int unsigned READ_WAIT   = 1,
    parameter int unsigned CMD_TIMEOUT = 255
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        i_frame_start,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [4:0]  o_ioc,
    output logic [7:0]  o_data_out,
    output logic [3:0]  o_cs,
    output logic        o_fetch_cmd,
    output logic        o_load_cmd,
    input  logic [31:0] i_rd_data,
    output logic [7:0]  o_err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        LOAD,
        FETCH,
        WAIT_RD,
        RESP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(CMD_TIMEOUT - 1);
    localparam logic [3:0] RD_LAST  = 4'(READ_WAIT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] tgt_q;
    logic [7:0] tmo_q;
    logic [3:0] rd_q;
    logic       cmd_take;
    logic       data_take;
    logic       timeout;
    logic       overrun;
    logic       rd_last;
    logic       strobe;

    // A frame start with a byte re-arms the decoder from any state.
    always_comb begin
        cmd_take  = i_rx_valid && (i_frame_start || state_q == IDLE);
        data_take = i_rx_valid && !i_frame_start && state_q == WAIT_DATA;
        timeout   = !i_rx_valid && !i_frame_start &&
                    state_q == WAIT_DATA && tmo_q == TMO_LAST;
        overrun   = i_rx_valid && !i_frame_start &&
                    (state_q inside {FETCH, WAIT_RD, RESP});
        rd_last   = state_q == WAIT_RD && rd_q == RD_LAST;
        state_d   = state_q;
        if (cmd_take) begin
            state_d = i_rx_byte[7] ? WAIT_DATA : FETCH;
        end else if (i_frame_start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      state_d = IDLE;
                WAIT_DATA: begin
                    if (data_take)    state_d = LOAD;
                    else if (timeout) state_d = IDLE;
                end
                LOAD:      state_d = IDLE;
                FETCH:     state_d = WAIT_RD;
                WAIT_RD:   if (rd_last) state_d = RESP;
                RESP:      if (i_tx_ready) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    assign o_load_cmd  = state_q == LOAD;
    assign o_fetch_cmd = state_q == FETCH;
    assign o_tx_valid  = state_q == RESP;
    assign strobe      = o_load_cmd | o_fetch_cmd;
    assign o_cs        = strobe ? (4'b0001 << tgt_q) : 4'b0000;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tgt_q      <= 2'd0;
            tmo_q      <= 8'd0;
            rd_q       <= 4'd0;
            o_ioc      <= 5'd0;
            o_data_out <= 8'h00;
            o_tx_byte  <= 8'h00;
            o_err_cnt  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (cmd_take) begin
                tgt_q <= i_rx_byte[6:5];
                o_ioc <= i_rx_byte[4:0];
            end
            if (data_take) begin
                o_data_out <= i_rx_byte;
            end
            tmo_q <= (state_q == WAIT_DATA && !cmd_take) ? tmo_q + 8'd1 : 8'd0;
            rd_q  <= (state_q == WAIT_RD) ? rd_q + 4'd1 : 4'd0;
            if (rd_last) begin
                o_tx_byte <= i_rd_data[8*tgt_q +: 8];
            end
            if ((overrun || timeout) && o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ioc_bus_master.sv
// tb_ioc_bus_master: directed stimulus with a latency-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_ioc_bus_master;

    localparam int RW = 1;
    localparam int CT = 10;

    logic        i_sys_clk;
    logic        i_rst;
    logic        i_frame_start;
    logic [7:0]  i_rx_byte;
    logic        i_rx_valid;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [4:0]  o_ioc;
    logic [7:0]  o_data_out;
    logic [3:0]  o_cs;
    logic        o_fetch_cmd;
    logic        o_load_cmd;
    logic [31:0] i_rd_data;
    logic [7:0]  o_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ioc_bus_master #(
        .READ_WAIT  (RW),
        .CMD_TIMEOUT(CT)
    ) dut (
        .i_sys_clk    (i_sys_clk),
        .i_rst        (i_rst),
        .i_frame_start(i_frame_start),
        .i_rx_byte    (i_rx_byte),
        .i_rx_valid   (i_rx_valid),
        .o_tx_byte    (o_tx_byte),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_ioc        (o_ioc),
        .o_data_out   (o_data_out),
        .o_cs         (o_cs),
        .o_fetch_cmd  (o_fetch_cmd),
        .o_load_cmd   (o_load_cmd),
        .i_rd_data    (i_rd_data),
        .o_err_cnt    (o_err_cnt)
    );

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: kind 0 = idle, 1 = awaiting write data, 2 = read.
    // age counts cycles since the command byte was accepted.
    int         m_kind;
    int         m_age;
    bit         m_load;
    logic [1:0] m_tgt;
    logic [4:0] m_ioc;
    logic [7:0] m_data;
    logic [7:0] m_tx;
    int         m_err;

    task automatic model_reset();
        m_kind = 0;
        m_age  = 0;
        m_load = 0;
        m_tgt  = 2'd0;
        m_ioc  = 5'd0;
        m_data = 8'h00;
        m_tx   = 8'h00;
        m_err  = 0;
    endtask

    task automatic model_step();
        bit ld;
        ld = 0;
        if (m_kind == 2 && m_age == 1 + RW) m_tx = i_rd_data[8*m_tgt +: 8];
        if (i_rx_valid && (m_kind == 0 || i_frame_start)) begin
            m_tgt  = i_rx_byte[6:5];
            m_ioc  = i_rx_byte[4:0];
            m_kind = i_rx_byte[7] ? 1 : 2;
            m_age  = 1;
        end else if (i_frame_start) begin
            m_kind = 0;
        end else if (m_kind == 1) begin
            if (i_rx_valid) begin
                m_data = i_rx_byte;
                ld     = 1;
                m_kind = 0;
            end else if (m_age == CT) begin
                if (m_err < 255) m_err++;
                m_kind = 0;
            end else begin
                m_age++;
            end
        end else if (m_kind == 2) begin
            if (i_rx_valid && m_err < 255) m_err++;
            if (m_age >= 2 + RW && i_tx_ready) m_kind = 0;
            else m_age++;
        end
        m_load = ld;
    endtask

    initial begin : compare
        bit       e_fetch;
        bit       e_valid;
        bit [3:0] e_cs;
        model_reset();
        forever begin
            @(negedge i_sys_clk);
            #2;
            if (i_rst) model_reset();
            e_fetch = (m_kind == 2 && m_age == 1);
            e_valid = (m_kind == 2 && m_age >= 2 + RW);
            e_cs    = (m_load || e_fetch) ? (4'b0001 << m_tgt) : 4'b0000;
            chk("m_load",  32'(o_load_cmd),  32'(m_load));
            chk("m_fetch", 32'(o_fetch_cmd), 32'(e_fetch));
            chk("m_cs",    32'(o_cs),        32'(e_cs));
            chk("m_valid", 32'(o_tx_valid),  32'(e_valid));
            chk("m_tx",    32'(o_tx_byte),   32'(m_tx));
            chk("m_ioc",   32'(o_ioc),       32'(m_ioc));
            chk("m_data",  32'(o_data_out),  32'(m_data));
            chk("m_err",   32'(o_err_cnt),   32'(m_err));
            if (!i_rst) model_step();
        end
    end

    task automatic cyc(input bit v, input logic [7:0] b, input bit fs,
                       input bit rdy);
        @(negedge i_sys_clk);
        i_rx_valid    = v;
        i_rx_byte     = b;
        i_frame_start = fs;
        i_tx_ready    = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
    endtask

    initial begin : stim
        i_rst         = 1'b1;
        i_frame_start = 1'b0;
        i_rx_byte     = 8'h00;
        i_rx_valid    = 1'b0;
        i_tx_ready    = 1'b0;
        i_rd_data     = 32'h0000_00AA;
        idle(1);
        #2;
        chk("rst_tx",   32'(o_tx_byte),  32'h00);
        chk("rst_err",  32'(o_err_cnt),  32'h00);
        chk("rst_cs",   32'(o_cs),       32'h0);
        idle(1);
        i_rst = 1'b0;

        // write: 0xA5 then 0x3C
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        idle(1);
        #2;
        chk("wr_load", 32'(o_load_cmd), 32'h1);
        chk("wr_cs",   32'(o_cs),       32'h2);
        chk("wr_ioc",  32'(o_ioc),      32'h05);
        chk("wr_data", 32'(o_data_out), 32'h3C);
        idle(1);
        #2;
        chk("wr_load_off", 32'(o_load_cmd), 32'h0);

        // read: 0x01, held response with ready low
        cyc(1, 8'h01, 0, 0);
        idle(1);
        #2;
        chk("rd_fetch", 32'(o_fetch_cmd), 32'h1);
        chk("rd_cs",    32'(o_cs),        32'h1);
        idle(1);
        #2;
        chk("rd_early", 32'(o_tx_valid), 32'h0);
        idle(1);
        #2;
        chk("rd_valid", 32'(o_tx_valid), 32'h1);
        chk("rd_byte",  32'(o_tx_byte),  32'hAA);
        idle(4);
        #2;
        chk("rd_hold_v", 32'(o_tx_valid), 32'h1);
        chk("rd_hold_b", 32'(o_tx_byte),  32'hAA);
        cyc(0, 8'h00, 0, 1);
        idle(1);
        #2;
        chk("rd_done", 32'(o_tx_valid), 32'h0);

        // timeout, then the next byte is a command
        i_rd_data = 32'h1122_BBAA;
        cyc(1, 8'h80, 0, 0);
        idle(CT);
        cyc(1, 8'h22, 0, 0);
        #2;
        chk("to_err",  32'(o_err_cnt), 32'h01);
        idle(1);
        #2;
        chk("to_fetch", 32'(o_fetch_cmd), 32'h1);
        chk("to_cs",    32'(o_cs),        32'h2);
        chk("to_ioc",   32'(o_ioc),       32'h02);
        idle(2);
        #2;
        chk("to_resp", 32'(o_tx_byte), 32'hBB);

        // overrun in RESP, then abort by frame start
        cyc(1, 8'h55, 0, 0);
        idle(1);
        #2;
        chk("ov_err",   32'(o_err_cnt),  32'h02);
        chk("ov_valid", 32'(o_tx_valid), 32'h1);
        chk("ov_byte",  32'(o_tx_byte),  32'hBB);
        cyc(0, 8'h00, 1, 0);
        idle(1);
        #2;
        chk("ab_valid", 32'(o_tx_valid), 32'h0);

        // frame start with a byte restarts the command
        cyc(1, 8'h9F, 0, 0);
        cyc(1, 8'hC3, 1, 0);
        cyc(1, 8'h77, 0, 0);
        idle(1);
        #2;
        chk("fs_load", 32'(o_load_cmd), 32'h1);
        chk("fs_cs",   32'(o_cs),       32'h4);
        chk("fs_ioc",  32'(o_ioc),      32'h03);
        chk("fs_data", 32'(o_data_out), 32'h77);

        // frame start during the fetch strobe
        cyc(1, 8'h61, 0, 0);
        cyc(0, 8'h00, 1, 0);
        #2;
        chk("ff_fetch", 32'(o_fetch_cmd), 32'h1);
        chk("ff_cs",    32'(o_cs),        32'h8);
        idle(4);

        // saturation
        for (int k = 0; k < 300; k++) begin
            cyc(1, 8'h80, 0, 0);
            idle(CT);
        end
        idle(1);
        #2;
        chk("sat_err", 32'(o_err_cnt), 32'hFF);

        // reset during WAIT_RD
        cyc(1, 8'h2A, 0, 0);
        idle(1);
        idle(1);
        i_rst = 1'b1;
        #2;
        chk("ar_cs",    32'(o_cs),        32'h0);
        chk("ar_fetch", 32'(o_fetch_cmd), 32'h0);
        chk("ar_valid", 32'(o_tx_valid),  32'h0);
        chk("ar_ioc",   32'(o_ioc),       32'h00);
        chk("ar_data",  32'(o_data_out),  32'h00);
        chk("ar_err",   32'(o_err_cnt),   32'h00);
        idle(2);
        i_rst = 1'b0;
        idle(6);
        #2;
        chk("ar_after", 32'(o_tx_valid), 32'h0);

        idle(1);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ioc_bus_master.md
IOC_BUS_MASTER -- requirements
Module: ioc_bus_master

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1: cycles between the fetch strobe and read-data capture (1..15).
REQ-002 SHALL have parameter CMD_TIMEOUT, default 255: maximum cycles to wait for a write data byte (1..255).
REQ-003 SHALL have port i_sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port i_frame_start, input, 1 bit: one-cycle pulse marking a new host frame (serial chip-select asserted).
REQ-006 SHALL have ports i_rx_byte (input, 8 bits) and i_rx_valid (input, 1 bit): host byte, qualified by a one-cycle valid pulse; no backpressure.
REQ-007 SHALL have ports o_tx_byte (output, 8 bits), o_tx_valid (output, 1 bit) and i_tx_ready (input, 1 bit): response byte to the host, using a valid/ready handshake.
REQ-008 SHALL have ports o_ioc (output, 5 bits) and o_data_out (output, 8 bits): register address and write data driven to the targets.
REQ-009 SHALL have port o_cs, output, 4 bits: one-hot target select.
REQ-010 SHALL have ports o_fetch_cmd (output, 1 bit) and o_load_cmd (output, 1 bit): read and write strobes to the targets.
REQ-011 SHALL have port i_rd_data, input, 32 bits: byte k is the read data from target k.
REQ-012 SHALL have port o_err_cnt, output, 8 bits: saturating error count.

Function
REQ-013 SHALL decode the command byte as: bit7 = 1 for write, 0 for read; bits[6:5] = target index; bits[4:0] = IOC.
REQ-014 SHALL use the FSM states IDLE, WAIT_DATA, LOAD, FETCH, WAIT_RD, RESP.
REQ-015 IDLE: on i_rx_valid, SHALL latch the command byte; go to WAIT_DATA if it is a write, otherwise go to FETCH.
REQ-016 WAIT_DATA: on i_rx_valid, SHALL latch the byte into o_data_out and go to LOAD.
REQ-017 WAIT_DATA: SHALL run a timeout counter that starts at 0 on entry; when it reaches CMD_TIMEOUT with no byte received, SHALL increment o_err_cnt and return to IDLE without a load.
REQ-018 LOAD: for exactly one cycle, SHALL assert o_cs[target] and o_load_cmd, with o_ioc and o_data_out stable; then go to IDLE.
REQ-019 FETCH: for exactly one cycle, SHALL assert o_cs[target] and o_fetch_cmd; then go to WAIT_RD.
REQ-020 WAIT_RD: SHALL count READ_WAIT cycles; in the last cycle, SHALL capture i_rd_data[8*target+7 -: 8] into o_tx_byte; then go to RESP.
REQ-021 RESP: SHALL hold o_tx_valid = 1 and o_tx_byte constant until a cycle with i_tx_ready = 1; in that cycle the transfer completes, and in the next cycle o_tx_valid = 0 and the state is IDLE.
REQ-022 Latency: a read command accepted in cycle N SHALL give the fetch strobe in N+1 and o_tx_valid in N+2+READ_WAIT.
REQ-023 A write data byte accepted in cycle M SHALL give the load strobe in M+1.
REQ-024 o_fetch_cmd and o_load_cmd SHALL never be high in the same cycle; o_cs SHALL be all-zero outside LOAD and FETCH.
REQ-025 o_ioc SHALL hold the latched IOC from the command until the next command is accepted.
REQ-026 An i_rx_valid in FETCH, WAIT_RD or RESP is an overrun: the byte SHALL be dropped and o_err_cnt incremented.
REQ-027 i_frame_start SHALL force IDLE from any state, deassert o_tx_valid and drop any pending response; a LOAD or FETCH strobe in that same cycle SHALL still complete.
REQ-028 When i_frame_start and i_rx_valid occur in the same cycle, the byte SHALL be taken as a new command, with the FSM entering WAIT_DATA or FETCH directly.
REQ-029 o_err_cnt SHALL saturate at 255; when an overrun and a timeout occur in the same cycle, it SHALL increment by 1 only.

Reset
REQ-030 While i_rst = 1, SHALL immediately set: state IDLE; o_cs = 0; o_fetch_cmd = o_load_cmd = 0; o_tx_valid = 0; o_tx_byte = 0x00; o_ioc = 0; o_data_out = 0x00; o_err_cnt = 0; timers 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no strobe generated after the reset edge.

Verification
REQ-032 Write: rx 0xA5, then 0x3C → o_cs = 4'b0010, o_ioc = 5'h05, o_data_out = 0x3C, o_load_cmd high for 1 cycle, one cycle after 0x3C.
REQ-033 Read: rx 0x01, i_rd_data = 0x000000AA, READ_WAIT = 1 → fetch in N+1, o_tx_byte = 0xAA with o_tx_valid in N+3; with i_tx_ready low for 5 cycles, both are held, then released.
REQ-034 Timeout: rx 0x80, no further byte, CMD_TIMEOUT = 10 → no load strobe, o_err_cnt = 1, and the next byte is decoded as a command.
REQ-035 Overrun/abort: during RESP, rx a byte → o_err_cnt + 1 and the response is unchanged; then pulse i_frame_start → o_tx_valid = 0 next cycle, state IDLE.
REQ-036 Saturation and reset: 300 timeouts → o_err_cnt = 255; assert i_rst during WAIT_RD → all outputs at their REQ-030 values and no o_tx_valid after release.
